irq_controller: RTL



---
 rtl/irq_pkg.sv | 16 +
 rtl/irq_prio_enc.sv | 20 ++
 rtl/irq_controller.sv | 110 +++++++++++
 3 files changed

// File: rtl/irq_pkg.sv
// Shared types and defaults for the interrupt controller slice.
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irq_state_t;

  localparam int NUM_IRQ_DEF = 4;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: the highest set index of the eligible vector wins.
module irq_prio_enc #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] eligible,
  output logic [W-1:0] idx,
  output logic         valid
);

  always_comb begin
    idx   = '0;
    valid = |eligible;
    // Ascending scan, so the last hit (highest index) is the one kept.
    for (int i = 0; i < N; i++) begin
      if (eligible[i]) idx = W'(i);
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Pending/mask capture with a single in-flight request/ack/done handshake.
// Build option IRQ_EDGE_DETECT_EN: pending sets on rising edges of p instead of levels.
//
// state   | meaning
// IDLE    | waiting for an eligible pending source
// REQ     | int1 high, x latched, waiting for irq_ack
// SERVICE | busy high, waiting for irq_done
module irq_controller
  import irq_pkg::*;
#(
  parameter int NUM_IRQ = NUM_IRQ_DEF,
  parameter int ID_W    = id_width(NUM_IRQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] p,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_wdata,
  input  logic               irq_ack,
  input  logic               irq_done,
  output logic               int1,
  output logic [ID_W-1:0]    x,
  output logic [NUM_IRQ-1:0] pending,
  output logic               busy
);

  irq_state_t         state_q, state_d;
  logic [ID_W-1:0]    x_q, x_d;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] mask_q, mask_d;
  logic [NUM_IRQ-1:0] set_vec, clr_vec, eligible;
  logic [ID_W-1:0]    sel_idx;
  logic               sel_valid;

`ifdef IRQ_EDGE_DETECT_EN
  logic [NUM_IRQ-1:0] p_q, p_d;

  always_comb p_d = p;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) p_q <= '0;
    else     p_q <= p_d;
  end

  assign set_vec = p & ~p_q;
`else
  assign set_vec = p;
`endif

  assign eligible = pending_q & ~mask_q;

  irq_prio_enc #(
    .N (NUM_IRQ),
    .W (ID_W)
  ) u_prio_enc (
    .eligible (eligible),
    .idx      (sel_idx),
    .valid    (sel_valid)
  );

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    clr_vec = '0;
    case (state_q)
      IDLE: begin
        if (sel_valid) begin
          x_d     = sel_idx;
          state_d = REQ;
        end
      end
      REQ: begin
        if (irq_ack) begin
          clr_vec = NUM_IRQ'(1) << x_q;
          state_d = SERVICE;
        end
      end
      SERVICE: begin
        if (irq_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A set landing in the same cycle as the ack clear keeps the bit pending.
  always_comb begin
    pending_d = (pending_q & ~clr_vec) | set_vec;
    mask_d    = mask_we ? mask_wdata : mask_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      x_q       <= '0;
      pending_q <= '0;
      mask_q    <= '0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      pending_q <= pending_d;
      mask_q    <= mask_d;
    end
  end

  assign int1    = (state_q == REQ);
  assign busy    = (state_q == SERVICE);
  assign x       = x_q;
  assign pending = pending_q;

endmodule
